// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 33-cycle MIPS HI/LO multiply/divide unit with MTHI/MTLO
//   clk, rst_n (sync active-low), start/op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU),
//   a (rs), b (rt), hi_we/lo_we (MTHI/MTLO), busy, done (pulse), div_zero, hi, lo
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2;
  logic [1:0] state_q, state_d, op_q, op_d;
  logic sa_q, sa_d, sb_q, sb_d, done_q, done_d, dz_q, dz_d;
  logic [WIDTH-1:0] ma_q, ma_d, mb_q, mb_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, addend, prod;
  logic [4:0] cnt_q, cnt_d;
  logic [WIDTH:0] trial, diff;
  logic [WIDTH-1:0] quo, rem, raw_a;
  logic sgn, ge;
  always_comb begin
    sgn = ~op_q[0];
    // restoring step: acc[63:32] is the partial remainder, acc[31:0] collects quotient bits
    trial = {acc_q[2*WIDTH-1:WIDTH], ma_q[5'd31 - cnt_q]};
    diff = trial - {1'b0, mb_q};
    // remainder < divisor keeps trial below 2*divisor, so bit 32 of diff is a clean borrow
    ge = ~diff[WIDTH];
    addend = mb_q[cnt_q] ? {{WIDTH{1'b0}}, ma_q} << cnt_q : '0;
    prod = (sgn && (sa_q ^ sb_q)) ? -acc_q : acc_q;
    quo = (sgn && (sa_q ^ sb_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem = (sgn && sa_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    // the dividend is kept only as a magnitude; rebuild its raw bits for the /0 result
    raw_a = (sgn && sa_q) ? -ma_q : ma_q;
    state_d = state_q;
    op_d = op_q;
    sa_d = sa_q;
    sb_d = sb_q;
    ma_d = ma_q;
    mb_d = mb_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    dz_d = dz_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        op_d = op;
        sa_d = a[WIDTH-1];
        sb_d = b[WIDTH-1];
        ma_d = (~op[0] && a[WIDTH-1]) ? -a : a;
        mb_d = (~op[0] && b[WIDTH-1]) ? -b : b;
        acc_d = '0;
        cnt_d = '0;
        dz_d = 1'b0;
        state_d = CALC;
      end else begin
        hi_d = hi_we ? a : hi_q;
        lo_d = lo_we ? a : lo_q;
      end
    end else if (state_q == CALC) begin
      acc_d = op_q[1] ? {ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0], acc_q[WIDTH-2:0], ge}
                      : acc_q + addend;
      cnt_d = cnt_q + 5'd1;
      state_d = (cnt_q == 5'd31) ? FIX : CALC;
    end else if (state_q == FIX) begin
      done_d = 1'b1;
      state_d = IDLE;
      if (!op_q[1]) begin
        {hi_d, lo_d} = prod;
      end else if (mb_q == '0) begin
        hi_d = raw_a;
        lo_d = '1;
        dz_d = 1'b1;
      end else begin
        hi_d = rem;
        lo_d = quo;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      ma_q <= '0;
      mb_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      dz_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      ma_q <= ma_d;
      mb_q <= mb_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      dz_q <= dz_d;
      done_q <= done_d;
    end
  end
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign div_zero = dz_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: random and directed checks of mult_div_unit against an arithmetic model
module tb_mult_div_unit;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic busy, done, div_zero;
  logic [31:0] hi, lo;
  int total = 0, bad = 0;
  mult_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // returns {div_zero, hi, lo}
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, sq, sr;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 2'd0) begin
      p = 64'(sx * sy);
      return {1'b0, p};
    end
    if (o == 2'd1) begin
      p = {32'b0, x} * {32'b0, y};
      return {1'b0, p};
    end
    if (y == 0) return {1'b1, x, 32'hFFFFFFFF};
    if (o == 2'd2) begin
      sq = sx / sy;
      sr = sx % sy;
      return {1'b0, sr[31:0], sq[31:0]};
    end
    return {1'b0, x % y, x / y};
  endfunction
  // called at a negedge; returns one negedge after the start edge
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic lw);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    lo_we = lw;
    @(negedge clk);
    start = 1'b0;
    lo_we = 1'b0;
    op = 2'($urandom);
    a = $urandom;
    b = $urandom;
    chk("busy_after_start", busy, 1);
    chk("done_low_in_calc", done, 0);
    chk("dz_cleared", div_zero, 0);
  endtask
  // poke>=0 raises an ignored start at that cycle; lw_busy drives MTLO throughout the run
  task automatic finish_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input int poke, input bit lw_busy);
    int n = 0;
    logic [64:0] e = model(o, x, y);
    while (!done && n < 40) begin
      start = (n == poke);
      if (n == poke) begin
        op = 2'd3;
        a = 32'd9;
        b = 32'd3;
      end
      if (lw_busy) begin
        lo_we = 1'b1;
        a = 32'h55;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    lo_we = 1'b0;
    chk({tag, "_latency"}, 64'(n), 64'd33);
    chk({tag, "_hi"}, hi, e[63:32]);
    chk({tag, "_lo"}, lo, e[31:0]);
    chk({tag, "_dz"}, div_zero, e[64]);
    chk({tag, "_busy_end"}, busy, 0);
  endtask
  initial begin
    logic [1:0] o;
    logic [31:0] x, y;
    logic seen;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);
    launch(2'd0, 32'hFFFFFFFD, 32'd5, 1'b0);
    finish_op("mult_neg", 2'd0, 32'hFFFFFFFD, 32'd5, -1, 1'b0);
    chk("mult_neg_hi_const", hi, 32'hFFFFFFFF);
    chk("mult_neg_lo_const", lo, 32'hFFFFFFF1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    launch(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    finish_op("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0);
    chk("multu_max_hi_const", hi, 32'hFFFFFFFE);
    launch(2'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    finish_op("div_neg", 2'd2, 32'hFFFFFFF9, 32'd2, -1, 1'b0);
    chk("div_neg_lo_const", lo, 32'hFFFFFFFD);
    launch(2'd3, 32'd7, 32'd2, 1'b0);
    finish_op("divu_b2b", 2'd3, 32'd7, 32'd2, -1, 1'b0);
    launch(2'd2, 32'h12345678, 32'd0, 1'b0);
    finish_op("div_zero", 2'd2, 32'h12345678, 32'd0, -1, 1'b0);
    chk("div_zero_flag_const", div_zero, 1);
    launch(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    finish_op("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0);
    chk("div_ovf_lo_const", lo, 32'h80000000);
    launch(2'd0, 32'd6, 32'd7, 1'b0);
    finish_op("ignored_start", 2'd0, 32'd6, 32'd7, 10, 1'b0);
    @(negedge clk);
    hi_we = 1'b1;
    a = 32'hDEADBEEF;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", hi, 32'hDEADBEEF);
    chk("mthi_lo_kept", lo, 32'd42);
    hi_we = 1'b1;
    lo_we = 1'b1;
    a = 32'hCAFEF00D;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    chk("mthi_both", hi, 32'hCAFEF00D);
    chk("mtlo_both", lo, 32'hCAFEF00D);
    launch(2'd1, 32'h1234, 32'd2, 1'b1);
    chk("mtlo_start_dropped", lo, 32'hCAFEF00D);
    finish_op("mtlo_busy", 2'd1, 32'h1234, 32'd2, -1, 1'b1);
    @(negedge clk);
    chk("mtlo_busy_after", lo, 32'h2468);
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      x = $urandom;
      y = $urandom;
      if (i % 8 == 0) y = 0;
      if (i % 8 == 1) y = $urandom_range(1, 7);
      if (i % 8 == 2) y = -$urandom_range(1, 7);
      if (i % 8 == 3) x = 32'h80000000;
      launch(o, x, y, 1'b0);
      finish_op("rand", o, x, y, -1, 1'b0);
    end
    launch(2'd0, 32'd11, 32'd13, 1'b0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_dz", div_zero, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | done;
    end
    chk("midrst_no_done", seen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
